// File: rtl/gaplus_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : gaplus_rom_loader
// Function : routes the HPS ioctl download into four ROM regions and
//            sequences the core reset around downloads and external resets.
// Revision : 1.0
// ============================================================================
module gaplus_rom_loader #(
   parameter int REGION_SHIFT = 14,
   parameter int TOTAL_BYTES  = 65536,
   parameter int HOLD_CYCLES  = 1024
) (
   input  logic                    clk_sys,
   input  logic                    RESET_N,
   input  logic                    ioctl_download,
   input  logic                    ioctl_wr,
   input  logic [24:0]             ioctl_addr,
   input  logic [7:0]              ioctl_dout,
   input  logic                    ext_rst,
   output logic [3:0]              rom_we,
   output logic [REGION_SHIFT-1:0] rom_addr,
   output logic [7:0]              rom_data,
   output logic                    core_reset,
   output logic                    load_done,
   output logic                    load_err,
   output logic [16:0]             byte_count,
   output logic [15:0]             checksum
);

   localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2,
      RUN  = 2'd3
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             dl_q;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_cnt_next;

   logic       rise;
   logic       fall;
   logic       in_load;
   logic       addr_ok;
   logic       accept;
   logic       reject;
   logic       err_final;
   logic [1:0] region;

   assign rise    = ioctl_download & ~dl_q;
   assign fall    = ~ioctl_download & dl_q;
   assign in_load = (state == LOAD);
   // one extra bit so a limit of 2^25 still compares correctly
   assign addr_ok = ({1'b0, ioctl_addr} < 26'(TOTAL_BYTES));
   assign accept  = in_load & ioctl_wr & addr_ok;
   assign reject  = in_load & ioctl_wr & ~addr_ok;
   assign region  = ioctl_addr[REGION_SHIFT+1 -: 2];

   // error status as it stands once this cycle's strobe is folded in;
   // a download that never accepted a byte counts as failed
   assign err_final = load_err | reject | ((byte_count == 17'd0) & ~accept);

   always_comb begin
      next_state    = state;
      hold_cnt_next = hold_cnt;
      if (rise) begin
         next_state = LOAD;
      end else begin
         case (state)
            BOOT: next_state = BOOT;
            LOAD: begin
               if (fall) begin
                  next_state    = HOLD;
                  hold_cnt_next = HOLD_LOAD;
               end
            end
            HOLD: begin
               if (ext_rst)
                  hold_cnt_next = HOLD_LOAD;
               else if (hold_cnt == '0)
                  next_state = RUN;
               else
                  hold_cnt_next = hold_cnt - CNT_W'(1);
            end
            RUN: begin
               if (ext_rst) begin
                  next_state    = HOLD;
                  hold_cnt_next = HOLD_LOAD;
               end
            end
            default: next_state = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= BOOT;
         dl_q       <= 1'b0;
         hold_cnt   <= '0;
         core_reset <= 1'b1;
      end else begin
         state      <= next_state;
         dl_q       <= ioctl_download;
         hold_cnt   <= hold_cnt_next;
         core_reset <= (next_state != RUN);
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         rom_we   <= 4'b0000;
         rom_addr <= '0;
         rom_data <= 8'h00;
      end else begin
         rom_we <= accept ? (4'b0001 << region) : 4'b0000;
         if (accept) begin
            rom_addr <= ioctl_addr[REGION_SHIFT-1:0];
            rom_data <= ioctl_dout;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         byte_count <= 17'd0;
         checksum   <= 16'h0000;
         load_err   <= 1'b0;
         load_done  <= 1'b0;
      end else if (rise) begin
         byte_count <= 17'd0;
         checksum   <= 16'h0000;
         load_err   <= 1'b0;
      end else if (in_load) begin
         if (accept) begin
            if (byte_count != '1)
               byte_count <= byte_count + 17'd1;
            checksum <= checksum + {8'h00, ioctl_dout};
         end
         if (fall) begin
            load_err <= err_final;
            if (!err_final)
               load_done <= 1'b1;
         end else if (reject) begin
            load_err <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gaplus_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gaplus_rom_loader
// Function : randomized and directed bench for gaplus_rom_loader against a
//            cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_gaplus_rom_loader;

   localparam int RS  = 14;
   localparam int TOT = 65536;
   localparam int H   = 16;

   logic        clk_sys = 1'b0;
   logic        RESET_N = 1'b1;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = 8'h00;
   logic        ext_rst = 1'b0;
   logic [3:0]  rom_we;
   logic [RS-1:0] rom_addr;
   logic [7:0]  rom_data;
   logic        core_reset;
   logic        load_done;
   logic        load_err;
   logic [16:0] byte_count;
   logic [15:0] checksum;

   gaplus_rom_loader #(
      .REGION_SHIFT (RS),
      .TOTAL_BYTES  (TOT),
      .HOLD_CYCLES  (H)
   ) dut (
      .clk_sys        (clk_sys),
      .RESET_N        (RESET_N),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ext_rst        (ext_rst),
      .rom_we         (rom_we),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .core_reset     (core_reset),
      .load_done      (load_done),
      .load_err       (load_err),
      .byte_count     (byte_count),
      .checksum       (checksum)
   );

   always #5 clk_sys = ~clk_sys;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: phase flags plus a remaining-hold count
   int m_loading = 0, m_running = 0, m_hold = 0, m_prev_dl = 0;
   int m_cnt = 0, m_sum = 0, m_err = 0, m_done = 0;
   int m_we = 0, m_addr = 0, m_data = 0;
   int m_rise = 0, m_fall = 0;

   always @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         m_loading = 0; m_running = 0; m_hold = 0; m_prev_dl = 0;
         m_cnt = 0; m_sum = 0; m_err = 0; m_done = 0;
         m_we = 0; m_addr = 0; m_data = 0;
      end else begin
         m_rise    = (ioctl_download && m_prev_dl == 0) ? 1 : 0;
         m_fall    = (!ioctl_download && m_prev_dl == 1) ? 1 : 0;
         m_prev_dl = ioctl_download ? 1 : 0;
         m_we      = 0;
         if (m_loading == 1 && ioctl_wr) begin
            if (int'(ioctl_addr) < TOT) begin
               m_we   = 1 << ((int'(ioctl_addr) >> RS) & 3);
               m_addr = int'(ioctl_addr) % (1 << RS);
               m_data = int'(ioctl_dout);
               if (m_cnt < 131071) m_cnt++;
               m_sum = (m_sum + int'(ioctl_dout)) % 65536;
            end else begin
               m_err = 1;
            end
         end
         if (m_rise == 1) begin
            m_loading = 1; m_running = 0; m_hold = 0;
            m_cnt = 0; m_sum = 0; m_err = 0;
         end else if (m_loading == 1) begin
            if (m_fall == 1) begin
               if (m_cnt == 0) m_err = 1;
               if (m_err == 0) m_done = 1;
               m_loading = 0;
               m_hold    = H;
            end
         end else if (m_hold > 0) begin
            if (ext_rst) m_hold = H;
            else begin
               m_hold--;
               if (m_hold == 0) m_running = 1;
            end
         end else if (m_running == 1 && ext_rst) begin
            m_running = 0;
            m_hold    = H;
         end
      end
   end

   always @(negedge clk_sys) begin
      if (cmp_en) begin
         chk("rom_we",     32'(rom_we),     32'(m_we));
         chk("rom_addr",   32'(rom_addr),   32'(m_addr));
         chk("rom_data",   32'(rom_data),   32'(m_data));
         chk("core_reset", 32'(core_reset), 32'(m_running == 0));
         chk("load_done",  32'(load_done),  32'(m_done));
         chk("load_err",   32'(load_err),   32'(m_err));
         chk("byte_count", 32'(byte_count), 32'(m_cnt));
         chk("checksum",   32'(checksum),   32'(m_sum));
      end
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wr_byte(input int a, input int d);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'(d);
      step();
      ioctl_wr   = 1'b0;
   endtask

   task automatic start_dl();
      ioctl_download = 1'b1;
      step();
   endtask

   task automatic end_dl();
      ioctl_download = 1'b0;
      step();
   endtask

   // counts edges from the current cycle until core_reset drops
   task automatic wait_run(output int n);
      n = 0;
      while (core_reset !== 1'b0 && n < 200) begin
         step();
         n++;
      end
   endtask

   int n;
   int nb;
   int a;

   initial begin
      #1 RESET_N = 1'b0;
      cmp_en = 1'b1;
      #1;
      chk("rst_core_reset", 32'(core_reset), 32'd1);
      chk("rst_byte_count", 32'(byte_count), 32'd0);
      step(); step();
      RESET_N = 1'b1;

      repeat (5000) step();
      chk("boot_core_reset", 32'(core_reset), 32'd1);
      chk("boot_load_done",  32'(load_done),  32'd0);

      // download with an out-of-range byte between two good ones
      start_dl();
      wr_byte(32'h0010, 8'h11);
      wr_byte(32'h10000, 8'h22);
      chk("bad_no_we", 32'(rom_we), 32'd0);
      wr_byte(32'h4020, 8'h33);
      chk("bad_next_we", 32'(rom_we), 32'b0010);
      end_dl();
      chk("bad_load_err",   32'(load_err),   32'd1);
      chk("bad_load_done",  32'(load_done),  32'd0);
      chk("bad_byte_count", 32'(byte_count), 32'd2);
      chk("bad_checksum",   32'(checksum),   32'h0044);
      wait_run(n);
      chk("bad_release", 32'(n), 32'(H));

      // empty download
      start_dl();
      repeat (3) step();
      end_dl();
      chk("empty_load_err",  32'(load_err),  32'd1);
      chk("empty_load_done", 32'(load_done), 32'd0);
      wait_run(n);
      chk("empty_release", 32'(n), 32'(H));

      // good download, back-to-back strobes
      start_dl();
      wr_byte(32'h0000, 8'h01);
      chk("good_we0",   32'(rom_we),   32'b0001);
      chk("good_addr0", 32'(rom_addr), 32'h0000);
      wr_byte(32'h4001, 8'h02);
      chk("good_we1",   32'(rom_we),   32'b0010);
      chk("good_addr1", 32'(rom_addr), 32'h0001);
      wr_byte(32'hC002, 8'hFF);
      chk("good_we2",   32'(rom_we),   32'b1000);
      chk("good_addr2", 32'(rom_addr), 32'h0002);
      chk("good_data2", 32'(rom_data), 32'h00FF);
      step();
      chk("good_we_off", 32'(rom_we),  32'd0);
      chk("good_hold_data", 32'(rom_data), 32'h00FF);
      end_dl();
      chk("good_checksum",   32'(checksum),   32'h0102);
      chk("good_byte_count", 32'(byte_count), 32'd3);
      chk("good_load_done",  32'(load_done),  32'd1);
      chk("good_load_err",   32'(load_err),   32'd0);
      wait_run(n);
      chk("good_release", 32'(n), 32'(H));

      // external reset pulse while running
      ext_rst = 1'b1;
      step();
      chk("ext_core_reset", 32'(core_reset), 32'd1);
      repeat (9) step();
      ext_rst = 1'b0;
      wait_run(n);
      chk("ext_release",    32'(n),          32'(H));
      chk("ext_byte_count", 32'(byte_count), 32'd3);
      chk("ext_checksum",   32'(checksum),   32'h0102);

      // randomized downloads with stray strobes and ext_rst
      for (int it = 0; it < 25; it++) begin
         for (int g = 0; g < int'($urandom_range(1, 30)); g++) begin
            ioctl_wr   = ($urandom_range(0, 3) == 0);
            ioctl_addr = 25'($urandom_range(0, 65535));
            ioctl_dout = 8'($urandom);
            ext_rst    = ($urandom_range(0, 7) == 0);
            step();
         end
         ioctl_wr = 1'b0;
         ext_rst  = 1'b0;
         start_dl();
         nb = $urandom_range(0, 30);
         for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom_range(65536, 33554431);
            else                           a = $urandom_range(0, 65535);
            wr_byte(a, $urandom_range(0, 255));
            ext_rst = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) step();
            ext_rst = 1'b0;
         end
         if ($urandom_range(0, 2) == 0) begin
            // strobe on the same edge the download falls
            ioctl_wr       = 1'b1;
            ioctl_addr     = 25'($urandom_range(0, 65535));
            ioctl_dout     = 8'($urandom);
            ioctl_download = 1'b0;
            step();
            ioctl_wr = 1'b0;
         end else begin
            end_dl();
         end
         if ($urandom_range(0, 1) == 0) begin
            wait_run(n);
            chk("rand_release", 32'(n), 32'(H));
         end
      end

      // asynchronous reset in the middle of a download
      start_dl();
      for (int b = 0; b < 100; b++) wr_byte($urandom_range(0, 65535), $urandom_range(0, 255));
      chk("mid_byte_count", 32'(byte_count), 32'd100);
      #2 RESET_N = 1'b0;
      #1;
      chk("mid_rst_we",         32'(rom_we),     32'd0);
      chk("mid_rst_byte_count", 32'(byte_count), 32'd0);
      chk("mid_rst_checksum",   32'(checksum),   32'd0);
      chk("mid_rst_core_reset", 32'(core_reset), 32'd1);
      chk("mid_rst_load_done",  32'(load_done),  32'd0);
      step();
      RESET_N = 1'b1;
      step();
      for (int b = 0; b < 5; b++) wr_byte($urandom_range(0, 65535), $urandom_range(0, 255));
      chk("restart_byte_count", 32'(byte_count), 32'd5);
      end_dl();
      chk("restart_load_done", 32'(load_done), 32'd1);
      wait_run(n);
      chk("restart_release", 32'(n), 32'(H));

      step();
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
